usb_dfu_download_sequencer: RTL and testbench
=============================================

# usb_dfu_download_sequencer

Sequencer between the DFU control-endpoint handler and the SPI flash bridge. It takes each DFU_DNLOAD block (block number, length, byte stream) and converts it into one flash page program operation: it computes the page address, holds the bridge's write request, streams the bytes, waits for program completion and reports DFU status. One DFU block maps to exactly one flash page (wTransferSize == PAGE_SIZE).

## Interface
- PAGE_SIZE, 256, flash page size in bytes; also the maximum DFU block length.
- BASE_PAGE, 16'h0000, flash page address of DFU block 0.
- NUM_PAGES, 16'd1024, number of writable pages; a block with block_num >= NUM_PAGES is rejected.
- TIMEOUT, 24'd12_000_000, maximum cycles to wait for flash acknowledge or completion.

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- dnload_start  in  1  one-cycle pulse: a new DNLOAD block is ready
- dnload_block  in  16  wBlockNum, sampled on dnload_start
- dnload_len  in  16  wLength, sampled on dnload_start; 0 = end of image
- dnload_data_avail  in  1  upstream has a byte on dnload_data
- dnload_data_get  out  1  byte consumed this cycle
- dnload_data  in  8  download byte
- status_clear  in  1  DFU_CLRSTATUS pulse; clears dfu_status
- dfu_busy  out  1  high while a block is in flight (reported as dfuDNBUSY)
- dfu_status  out  8  DFU bStatus code, sticky until status_clear
- dnload_done  out  1  one-cycle pulse when a block finishes (success or error)
- manifest  out  1  one-cycle pulse on a zero-length block
- address  out  16  flash page address to the bridge
- wr_request  out  1  write request to the bridge
- wr_busy  in  1  bridge erase/program in progress
- wr_data_avail  out  1  byte available to the bridge
- wr_data_get  in  1  bridge took a byte
- wr_data  out  8  byte to the bridge

## Operation
- States: IDLE, REQ, STREAM, DRAIN, DONE.
- IDLE, on dnload_start:
  - len == 0: go to DONE, pulse manifest. No flash activity.
  - len > PAGE_SIZE: set dfu_status = 8'h03 (errWRITE) and go to DONE.
  - block >= NUM_PAGES: set dfu_status = 8'h08 (errADDRESS) and go to DONE.
  - Otherwise: latch address = BASE_PAGE + block (16-bit, wraps), latch len, clear byte count, assert wr_request and go to REQ.
- REQ: wait for wr_busy = 1, which is the bridge's acknowledge, then go to STREAM.
- STREAM:
  - Pass-through: wr_data = dnload_data; wr_data_avail = dnload_data_avail && (count < len); dnload_data_get = wr_data_get.
  - count (9 bits) increments on each wr_data_get.
  - When count == len, deassert wr_request and go to DRAIN. Upstream stalls (avail low) are waited out indefinitely.
- DRAIN: wait for wr_busy = 0, then go to DONE.
- DONE: pulse dnload_done for one cycle, then return to IDLE.
- Timeout: a counter runs in REQ and DRAIN and clears on each state entry. When it reaches TIMEOUT: dfu_status = 8'h06 (errPROG), drop wr_request, go to DONE.
- dfu_busy = (state != IDLE).
- Short block (len < PAGE_SIZE): the rest of the page is not written.
- Errors do not overwrite an existing non-zero dfu_status; the first error wins.
- status_clear sets dfu_status to 0 and takes priority over a simultaneous error.
- dnload_start while not in IDLE:
  - Ignored.
  - If dfu_status is 0, set it to 8'h0F (errSTALLEDPKT).

## Timing
- Reset values: all outputs 0, state IDLE. Reset is asynchronous and mid-operation it aborts immediately: wr_request falls without waiting for the bridge.
- wr_request rises on the clock edge after dnload_start; address is valid on the same cycle and is held stable until DONE.
- Data path is combinational in STREAM: zero added latency, one byte per cycle when the bridge and upstream allow.
- wr_request falls on the edge after the last wr_data_get.
- dnload_done rises one cycle after wr_busy is sampled low in DRAIN.
- dnload_done is also asserted 2 cycles after dnload_start for rejected or zero-length blocks.
- manifest is coincident with dnload_done.

## Structure
- A shared package holds:
  - the DFU bStatus constants (OK, errWRITE, errPROG, errADDRESS, errSTALLEDPKT);
  - the state encoding.
- The timeout counter is a natural sub-module, `usb_timeout_counter`: clear, enable, expired.
- Everything else stays in one module.

## Test plan
- **Full page:** start with block=3, len=256, BASE_PAGE=16'h0100; the bridge model takes one byte per cycle and holds wr_busy for 50 cycles after wr_request falls. Required: address=16'h0103, 256 bytes delivered in order, then dnload_done, dfu_status=0.
- **Short block:** len=16 with upstream avail toggling every other cycle. Required: exactly 16 wr_data_get, wr_request low after the 16th, done, status 0.
- **Zero length:** start with len=0. Required: manifest and dnload_done 2 cycles later, wr_request never high.
- **Rejected and out-of-order starts:**
  - block=NUM_PAGES: status 8'h08, no wr_request.
  - status_clear: status returns to 0.
  - start with len=300: status 8'h03.
  - start during STREAM: ignored, status 8'h0F, the transfer in flight completes normally.
- **Timeout:** wr_busy stuck high after streaming, TIMEOUT set to 100. Required: status 8'h06 and dnload_done at 100 cycles into DRAIN.
- **Reset mid-stream:** assert reset after 40 bytes. Required: all outputs 0 asynchronously; the next block after release runs normally.

Source files
------------

// File: rtl/usb_dfu_download_sequencer_pkg.sv
// Shared definitions for the DFU download sequencer: DFU bStatus codes and FSM state encoding.
package usb_dfu_download_sequencer_pkg;

  localparam int unsigned STATUS_W  = 8;
  localparam int unsigned TIMEOUT_W = 24;

  localparam logic [STATUS_W-1:0] DFU_OK             = 8'h00;
  localparam logic [STATUS_W-1:0] DFU_ERR_WRITE      = 8'h03;
  localparam logic [STATUS_W-1:0] DFU_ERR_PROG       = 8'h06;
  localparam logic [STATUS_W-1:0] DFU_ERR_ADDRESS    = 8'h08;
  localparam logic [STATUS_W-1:0] DFU_ERR_STALLEDPKT = 8'h0F;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } dfu_state_e;

endpackage

// File: rtl/usb_dfu_download_sequencer_timeout.sv
// Cycle counter that flags expiry once it has counted LIMIT enabled cycles since the last clear.
module usb_timeout_counter #(
  parameter int unsigned    W     = 24,
  parameter logic [W-1:0]   LIMIT = '1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [W-1:0] cnt;

  // Saturates once expired so the flag stays up until the owner clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (enable && !expired) begin
      cnt     <= cnt + W'(1);
      expired <= (cnt == LIMIT - W'(1));
    end
  end

endmodule

// File: rtl/usb_dfu_download_sequencer.sv
// Turns each DFU_DNLOAD block into one SPI flash page program and reports DFU status.
module usb_dfu_download_sequencer
  import usb_dfu_download_sequencer_pkg::*;
#(
  parameter int unsigned            PAGE_SIZE = 256,
  parameter logic [15:0]            BASE_PAGE = 16'h0000,
  parameter logic [15:0]            NUM_PAGES = 16'd1024,
  parameter logic [TIMEOUT_W-1:0]   TIMEOUT   = 24'd12_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dnload_start,
  input  logic [15:0]         dnload_block,
  input  logic [15:0]         dnload_len,
  input  logic                dnload_data_avail,
  output logic                dnload_data_get,
  input  logic [7:0]          dnload_data,
  input  logic                status_clear,
  output logic                dfu_busy,
  output logic [STATUS_W-1:0] dfu_status,
  output logic                dnload_done,
  output logic                manifest,
  output logic [15:0]         address,
  output logic                wr_request,
  input  logic                wr_busy,
  output logic                wr_data_avail,
  input  logic                wr_data_get,
  output logic [7:0]          wr_data
);

  localparam int unsigned CNT_W = $clog2(PAGE_SIZE + 1);

  dfu_state_e          state, state_next;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    len_q;
  logic                manifest_pend;
  logic                err_valid;
  logic [STATUS_W-1:0] err_code;
  logic                tmo_enable;
  logic                tmo_expired;
  logic                in_stream;
  logic                room;
  logic                get_ok;

  assign in_stream  = (state == ST_STREAM);
  assign room       = (count < len_q);
  assign get_ok     = in_stream && room && wr_data_get;
  assign tmo_enable = (state == ST_REQ) || (state == ST_DRAIN);

  // Zero-latency byte path between upstream and the bridge while streaming.
  assign wr_data         = in_stream ? dnload_data : 8'h00;
  assign wr_data_avail   = in_stream && room && dnload_data_avail;
  assign dnload_data_get = get_ok;

  usb_timeout_counter #(
    .W     (TIMEOUT_W),
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (!tmo_enable),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  // Next-state and error decode.
  always_comb begin
    state_next = state;
    err_valid  = 1'b0;
    err_code   = DFU_OK;
    case (state)
      ST_IDLE: begin
        if (dnload_start) begin
          if (dnload_len == 16'd0) begin
            state_next = ST_DONE;
          end else if (dnload_len > 16'(PAGE_SIZE)) begin
            state_next = ST_DONE;
            err_valid  = 1'b1;
            err_code   = DFU_ERR_WRITE;
          end else if (dnload_block >= NUM_PAGES) begin
            state_next = ST_DONE;
            err_valid  = 1'b1;
            err_code   = DFU_ERR_ADDRESS;
          end else begin
            state_next = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (wr_busy) begin
          state_next = ST_STREAM;
        end else if (tmo_expired) begin
          state_next = ST_DONE;
          err_valid  = 1'b1;
          err_code   = DFU_ERR_PROG;
        end
      end
      ST_STREAM: begin
        if (get_ok && ((count + CNT_W'(1)) == len_q)) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!wr_busy) begin
          state_next = ST_DONE;
        end else if (tmo_expired) begin
          state_next = ST_DONE;
          err_valid  = 1'b1;
          err_code   = DFU_ERR_PROG;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    // A start arriving mid-block is dropped and flagged as a stalled packet.
    if (dnload_start && (state != ST_IDLE) && !err_valid) begin
      err_valid = 1'b1;
      err_code  = DFU_ERR_STALLEDPKT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      count         <= '0;
      len_q         <= '0;
      manifest_pend <= 1'b0;
      dfu_busy      <= 1'b0;
      dfu_status    <= DFU_OK;
      dnload_done   <= 1'b0;
      manifest      <= 1'b0;
      address       <= 16'h0000;
      wr_request    <= 1'b0;
    end else begin
      state       <= state_next;
      dfu_busy    <= (state_next != ST_IDLE);
      wr_request  <= (state_next == ST_REQ) || (state_next == ST_STREAM);
      dnload_done <= (state == ST_DONE);
      manifest    <= (state == ST_DONE) && manifest_pend;

      if ((state == ST_IDLE) && (state_next == ST_REQ)) begin
        address <= BASE_PAGE + dnload_block;
        len_q   <= CNT_W'(dnload_len);
        count   <= '0;
      end else if (get_ok) begin
        count <= count + CNT_W'(1);
      end

      if ((state == ST_IDLE) && dnload_start && (dnload_len == 16'd0)) begin
        manifest_pend <= 1'b1;
      end else if (state == ST_DONE) begin
        manifest_pend <= 1'b0;
      end

      // Clear beats a same-cycle error; otherwise the first error sticks.
      if (status_clear) begin
        dfu_status <= DFU_OK;
      end else if (err_valid && (dfu_status == DFU_OK)) begin
        dfu_status <= err_code;
      end
    end
  end

endmodule

// File: tb/tb_usb_dfu_download_sequencer.sv
// Directed bench for usb_dfu_download_sequencer: table of single-shot starts plus bridge-driven transfers.
module tb_usb_dfu_download_sequencer;

  localparam logic [15:0] BASE = 16'h0100;
  localparam int          TMO  = 100;

  logic        clk;
  logic        reset;
  logic        dnload_start;
  logic [15:0] dnload_block;
  logic [15:0] dnload_len;
  logic        dnload_data_avail;
  logic        dnload_data_get;
  logic [7:0]  dnload_data;
  logic        status_clear;
  logic        dfu_busy;
  logic [7:0]  dfu_status;
  logic        dnload_done;
  logic        manifest;
  logic [15:0] address;
  logic        wr_request;
  logic        wr_busy;
  logic        wr_data_avail;
  logic        wr_data_get;
  logic [7:0]  wr_data;

  int tests;
  int fails;

  usb_dfu_download_sequencer #(
    .BASE_PAGE (BASE),
    .TIMEOUT   (24'(TMO))
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .dnload_start      (dnload_start),
    .dnload_block      (dnload_block),
    .dnload_len        (dnload_len),
    .dnload_data_avail (dnload_data_avail),
    .dnload_data_get   (dnload_data_get),
    .dnload_data       (dnload_data),
    .status_clear      (status_clear),
    .dfu_busy          (dfu_busy),
    .dfu_status        (dfu_status),
    .dnload_done       (dnload_done),
    .manifest          (manifest),
    .address           (address),
    .wr_request        (wr_request),
    .wr_busy           (wr_busy),
    .wr_data_avail     (wr_data_avail),
    .wr_data_get       (wr_data_get),
    .wr_data           (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          clear_first;
    bit          clear_with_start;
    logic [15:0] blk;
    logic [15:0] len;
    logic [7:0]  exp_status;
    bit          exp_manifest;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i, input logic [15:0] b);
    return 8'(i * 7 + int'(b));
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({dnload_data_get, dfu_busy, dfu_status, dnload_done, manifest,
                address, wr_request, wr_data_avail, wr_data});
  endfunction

  task automatic pulse_clear();
    @(negedge clk);
    status_clear = 1'b1;
    @(negedge clk);
    status_clear = 1'b0;
    check("status_clear", dfu_status, 8'h00);
  endtask

  // Drives one block through a simple bridge model; hold < 0 keeps wr_busy stuck.
  task automatic run_block(input logic [15:0] blk, input int len, input bit toggle,
                           input int hold, input bit inject, input int abort_at,
                           input logic [7:0] exp_status);
    int got, fall_cyc, drop_cyc, last_get, busy_left;
    bit acked, fell, order_ok, injected, done_seen;
    got = 0; fall_cyc = -1; drop_cyc = -1; last_get = -1; busy_left = 0;
    acked = 0; fell = 0; order_ok = 1; injected = 0; done_seen = 0;
    @(negedge clk);
    dnload_block = blk;
    dnload_len   = 16'(len);
    dnload_start = 1'b1;
    @(negedge clk);
    dnload_start = 1'b0;
    check("req_rise", wr_request, 1);
    check("address", address, BASE + blk);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (abort_at >= 0 && got == abort_at) begin
        reset = 1'b0;
        wr_data_get = 1'b0;
        wr_busy = 1'b0;
        dnload_data_avail = 1'b0;
        #1;
        check("reset_async", all_outs(), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      if (dnload_done) begin
        done_seen = 1;
        check("status", dfu_status, exp_status);
        check("busy_clear", dfu_busy, 0);
        check("bytes", got, len);
        check("data_order", order_ok, 1);
        check("req_fall", fall_cyc, last_get + 1);
        if (hold < 0)
          check("timeout_window", ((cyc - fall_cyc) >= TMO) && ((cyc - fall_cyc) <= TMO + 3), 1);
        else
          check("done_latency", cyc, drop_cyc + 2);
        break;
      end
      if (acked && !fell && !wr_request) begin
        fell = 1;
        fall_cyc = cyc;
        busy_left = hold;
      end else if (fell && hold >= 0 && wr_busy) begin
        if (busy_left == 0) begin
          wr_busy = 1'b0;
          drop_cyc = cyc;
        end else begin
          busy_left--;
        end
      end
      if (!acked && wr_request) begin
        wr_busy = 1'b1;
        acked = 1;
      end
      dnload_start = 1'b0;
      if (inject && !injected && got == 10) begin
        dnload_start = 1'b1;
        dnload_block = 16'd7;
        dnload_len   = 16'd8;
        injected = 1;
      end
      dnload_data_avail = toggle ? ((cyc % 2) == 1) : 1'b1;
      dnload_data = pat(got, blk);
      #1;
      wr_data_get = wr_data_avail;
      if (wr_data_avail) begin
        if (wr_data !== pat(got, blk)) order_ok = 0;
        got++;
        last_get = cyc;
      end
      #1;
      if (dnload_data_get !== wr_data_get) order_ok = 0;
      @(negedge clk);
    end
    if (!done_seen) check("done_timeout", 0, 1);
    wr_data_get = 1'b0;
    dnload_data_avail = 1'b0;
    dnload_start = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    dnload_start = 1'b0;
    dnload_block = 16'h0;
    dnload_len = 16'h0;
    dnload_data_avail = 1'b0;
    dnload_data = 8'h0;
    status_clear = 1'b0;
    wr_busy = 1'b0;
    wr_data_get = 1'b0;

    vecs[0] = '{0, 0, 16'd0,      16'd0,   8'h00, 1};
    vecs[1] = '{0, 0, 16'd1024,   16'd16,  8'h08, 0};
    vecs[2] = '{1, 0, 16'd5,      16'd300, 8'h03, 0};
    vecs[3] = '{0, 0, 16'd2000,   16'd10,  8'h03, 0};
    vecs[4] = '{1, 0, 16'hFFFF,   16'd0,   8'h00, 1};
    vecs[5] = '{0, 1, 16'd1024,   16'd4,   8'h00, 0};

    repeat (3) @(negedge clk);
    check("reset_values", all_outs(), 64'h0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].clear_first) pulse_clear();
      @(negedge clk);
      dnload_block = vecs[i].blk;
      dnload_len   = vecs[i].len;
      dnload_start = 1'b1;
      status_clear = vecs[i].clear_with_start;
      @(negedge clk);
      dnload_start = 1'b0;
      status_clear = 1'b0;
      check($sformatf("vec%0d_early_done", i), dnload_done, 0);
      check($sformatf("vec%0d_req_low1", i), wr_request, 0);
      @(negedge clk);
      check($sformatf("vec%0d_done", i), dnload_done, 1);
      check($sformatf("vec%0d_manifest", i), manifest, vecs[i].exp_manifest);
      check($sformatf("vec%0d_status", i), dfu_status, vecs[i].exp_status);
      check($sformatf("vec%0d_req_low2", i), wr_request, 0);
    end

    run_block(16'd3, 256, 0, 50, 0, -1, 8'h00);
    run_block(16'd9, 16, 1, 5, 0, -1, 8'h00);
    run_block(16'd4, 64, 0, 10, 1, -1, 8'h0F);
    pulse_clear();
    run_block(16'd2, 8, 0, -1, 0, -1, 8'h06);
    wr_busy = 1'b0;
    pulse_clear();
    run_block(16'd6, 100, 0, 10, 0, 40, 8'h00);
    check("post_reset_status", dfu_status, 8'h00);
    run_block(16'd7, 32, 0, 5, 0, -1, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
